tank_model: RTL and testbench

Closed-loop plant model of the pumped water tank: consumes the two pump commands produced by the pump controller and returns the 8-bit water level the controller reads. It supplies realistic input dynamics for the controller on the board and in simulation, so the controller can be exercised without a physical tank. Pump motors have a spin-up delay, the level integrates net flow on a slow tick, and flags report overflow, dry-run and contention conditions.

---
 rtl/tank_model_if.sv | 27 ++
 rtl/tank_model.sv | 156 +++++++++++++++
 tb/tb_tank_model.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/tank_model_if.sv
// tank_model_if: pump commands in, level and status flags out.
// master = pump controller side, slave = tank plant side.
interface tank_model_if;
  logic       pump1_ctrl;
  logic       pump2_ctrl;
  logic       hold;
  logic [7:0] water_lvl;
  logic       step;
  logic       pump1_run;
  logic       pump2_run;
  logic       overflow;
  logic       dry_run;
  logic       spill;
  logic       both_on;

  modport master (
    output pump1_ctrl, pump2_ctrl, hold,
    input  water_lvl, step, pump1_run, pump2_run,
    input  overflow, dry_run, spill, both_on
  );

  modport slave (
    input  pump1_ctrl, pump2_ctrl, hold,
    output water_lvl, step, pump1_run, pump2_run,
    output overflow, dry_run, spill, both_on
  );
endinterface

// File: rtl/tank_model.sv
// tank_model: pumped water tank plant with spin-up pumps,
// tick-integrated level and overflow/dry-run/contention flags.
module tank_model #(
  parameter int TICK_DIV     = 1_000_000,
  parameter int SPINUP_TICKS = 3,
  parameter int FILL_RATE    = 2,
  parameter int DRAIN_RATE   = 1,
  parameter int MAX_LVL      = 100,
  parameter int INIT_LVL     = 0
) (
  input logic         CLK100MHZ,
  input logic         CPU_RESETN,
  tank_model_if.slave tank
);

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SPINUP = 2'd1,
    RUN    = 2'd2
  } st_t;

  localparam logic [23:0] C_LAST  = 24'(TICK_DIV - 1);
  localparam logic [7:0]  C_SPLST = 8'(SPINUP_TICKS - 1);
  localparam logic signed [9:0] C_MAX  = 10'(MAX_LVL);
  localparam logic signed [9:0] C_FILL = 10'(FILL_RATE);
  localparam logic signed [9:0] C_DRN  = 10'(DRAIN_RATE);

  logic [23:0] r_cnt;
  logic        w_tick;
  logic [1:0]  w_cmd;

  st_t         r_st   [2];
  st_t         w_st_nx[2];
  logic [7:0]  r_sc   [2];
  logic [7:0]  w_sc_nx[2];

  logic [7:0]  r_lvl;
  logic        r_step;
  logic        r_ovf;
  logic        r_dry;
  logic        r_spill;
  logic        r_both;
  logic [1:0]  r_run;

  logic signed [9:0] w_sum;
  logic              w_ovf;
  logic              w_dry;
  logic [7:0]        w_clamp;

  assign w_cmd  = {tank.pump2_ctrl, tank.pump1_ctrl};
  assign w_tick = (r_cnt == C_LAST) & ~tank.hold;

  // tick divider; hold freezes the count
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_cnt <= '0;
    end else if (!tank.hold) begin
      r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 24'd1;
    end
  end

  // pump FSM state registers
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_st[0] <= OFF;
      r_st[1] <= OFF;
      r_sc[0] <= '0;
      r_sc[1] <= '0;
    end else begin
      r_st[0] <= w_st_nx[0];
      r_st[1] <= w_st_nx[1];
      r_sc[0] <= w_sc_nx[0];
      r_sc[1] <= w_sc_nx[1];
    end
  end

  // pump FSM next state; dropping a command always wins
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_st_nx[i] = r_st[i];
      w_sc_nx[i] = r_sc[i];
      if (!w_cmd[i]) begin
        w_st_nx[i] = OFF;
        w_sc_nx[i] = '0;
      end else begin
        unique case (r_st[i])
          OFF: begin
            w_st_nx[i] = SPINUP;
            w_sc_nx[i] = '0;
          end
          SPINUP: begin
            if (w_tick) begin
              if (r_sc[i] == C_SPLST) begin
                w_st_nx[i] = RUN;
                w_sc_nx[i] = '0;
              end else begin
                w_sc_nx[i] = r_sc[i] + 8'd1;
              end
            end
          end
          RUN: w_st_nx[i] = RUN;
          default: begin
            w_st_nx[i] = OFF;
            w_sc_nx[i] = '0;
          end
        endcase
      end
    end
  end

  // net flow from pre-edge pump states, then clamp
  always_comb begin
    w_sum = $signed({2'b00, r_lvl});
    if (r_st[0] == RUN) w_sum = w_sum + C_FILL;
    if (r_st[1] == RUN) w_sum = w_sum - C_DRN;
    w_ovf   = (w_sum > C_MAX);
    w_dry   = w_sum[9];
    w_clamp = w_sum[7:0];
    if (w_ovf) w_clamp = C_MAX[7:0];
    if (w_dry) w_clamp = '0;
  end

  // level integrator and status flags
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_lvl   <= 8'(INIT_LVL);
      r_step  <= 1'b0;
      r_ovf   <= 1'b0;
      r_dry   <= 1'b0;
      r_spill <= 1'b0;
      r_both  <= 1'b0;
      r_run   <= '0;
    end else begin
      r_step <= w_tick;
      r_ovf  <= w_tick & w_ovf;
      r_dry  <= w_tick & w_dry;
      if (w_tick) begin
        r_lvl   <= w_clamp;
        r_spill <= r_spill | w_ovf;
      end
      r_run[0] <= (r_st[0] == RUN);
      r_run[1] <= (r_st[1] == RUN);
      r_both   <= (r_st[0] == RUN) & (r_st[1] == RUN);
    end
  end

  assign tank.water_lvl = r_lvl;
  assign tank.step      = r_step;
  assign tank.overflow  = r_ovf;
  assign tank.dry_run   = r_dry;
  assign tank.spill     = r_spill;
  assign tank.both_on   = r_both;
  assign tank.pump1_run = r_run[0];
  assign tank.pump2_run = r_run[1];

endmodule

// File: tb/tb_tank_model.sv
// tb_tank_model: directed scenarios for tank_model with a
// step scoreboard of expected {level, overflow, dry_run}.
module tb_tank_model;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tank_model_if bus ();

  tank_model #(
    .TICK_DIV    (4),
    .SPINUP_TICKS(2),
    .FILL_RATE   (3),
    .DRAIN_RATE  (2),
    .MAX_LVL     (100),
    .INIT_LVL    (0)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .tank      (bus)
  );

  int   sb[$];
  int   errors = 0;
  int   checks = 0;
  logic p1_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      p1_seen = p1_seen | bus.pump1_run;
    end while (bus.step !== 1'b1 && n < 40);
  endtask

  task automatic step_chk(input string tag, input int l,
                          input int o, input int d, output int n);
    int e;
    sb.push_back(l * 4 + o * 2 + d);
    wait_step(n);
    chk({tag, "_step"}, 32'(bus.step), 32'd1);
    e = sb.pop_front();
    chk(tag, 32'({bus.water_lvl, bus.overflow, bus.dry_run}), 32'(e));
  endtask

  initial begin
    int n;
    logic any_step;
    logic same;
    logic [7:0] lv;

    bus.pump1_ctrl = 1'b1;
    bus.pump2_ctrl = 1'b1;
    bus.hold       = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", 32'({bus.water_lvl, bus.step, bus.overflow,
        bus.dry_run, bus.spill, bus.both_on, bus.pump1_run,
        bus.pump2_run}), 32'd0);

    bus.pump2_ctrl = 1'b0;
    rst_n = 1'b1;
    step_chk("fill_s1", 0, 0, 0, n);
    chk("first_step_lat", 32'(n), 32'd4);
    chk("p1_run_early", 32'(bus.pump1_run), 32'd0);
    step_chk("fill_s2", 0, 0, 0, n);
    step_chk("fill_s3", 3, 0, 0, n);
    chk("p1_run", 32'(bus.pump1_run), 32'd1);
    for (int k = 2; k <= 14; k++) step_chk("fill", 3 * k, 0, 0, n);

    bus.pump2_ctrl = 1'b1;
    step_chk("cont_sp1", 45, 0, 0, n);
    step_chk("cont_sp2", 48, 0, 0, n);
    step_chk("cont_49", 49, 0, 0, n);
    step_chk("cont_50", 50, 0, 0, n);
    chk("both_on", 32'(bus.both_on), 32'd1);
    step_chk("cont_51", 51, 0, 0, n);
    step_chk("cont_52", 52, 0, 0, n);
    step_chk("cont_53", 53, 0, 0, n);
    step_chk("cont_54", 54, 0, 0, n);

    bus.pump2_ctrl = 1'b0;
    for (int j = 0; j < 15; j++) step_chk("fill_hi", 57 + 3 * j, 0, 0, n);
    chk("spill_pre", 32'(bus.spill), 32'd0);
    step_chk("ovf_1", 100, 1, 0, n);
    chk("spill_1", 32'(bus.spill), 32'd1);
    step_chk("ovf_2", 100, 1, 0, n);
    chk("spill_2", 32'(bus.spill), 32'd1);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_spill", 32'({bus.spill, bus.water_lvl}), 32'd0);
    rst_n = 1'b1;
    step_chk("f2_0a", 0, 0, 0, n);
    step_chk("f2_0b", 0, 0, 0, n);
    step_chk("f2_3", 3, 0, 0, n);
    step_chk("f2_6", 6, 0, 0, n);
    step_chk("f2_9", 9, 0, 0, n);
    bus.pump1_ctrl = 1'b0;
    step_chk("p1_off", 9, 0, 0, n);

    bus.pump1_ctrl = 1'b1;
    p1_seen = 1'b0;
    step_chk("abort_sp", 9, 0, 0, n);
    bus.pump1_ctrl = 1'b0;
    step_chk("abort_lvl", 9, 0, 0, n);
    chk("abort_p1_run", 32'(p1_seen), 32'd0);

    bus.hold = 1'b1;
    any_step = 1'b0;
    same = 1'b1;
    lv = bus.water_lvl;
    repeat (10) begin
      @(negedge clk);
      any_step = any_step | bus.step;
      if (bus.water_lvl !== lv) same = 1'b0;
    end
    bus.hold = 1'b0;
    chk("hold_step", 32'(any_step), 32'd0);
    chk("hold_lvl", 32'(same), 32'd1);

    bus.pump2_ctrl = 1'b1;
    step_chk("drn_sp1", 9, 0, 0, n);
    step_chk("drn_sp2", 9, 0, 0, n);
    step_chk("drn_7", 7, 0, 0, n);
    step_chk("drn_5", 5, 0, 0, n);
    step_chk("drn_3", 3, 0, 0, n);
    step_chk("drn_1", 1, 0, 0, n);
    step_chk("dry_1", 0, 0, 1, n);
    step_chk("dry_2", 0, 0, 1, n);

    bus.pump2_ctrl = 1'b0;
    bus.pump1_ctrl = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step_chk("f3_0a", 0, 0, 0, n);
    step_chk("f3_0b", 0, 0, 0, n);
    for (int k = 1; k <= 11; k++) step_chk("f3", 3 * k, 0, 0, n);
    bus.pump2_ctrl = 1'b1;
    step_chk("f3_36", 36, 0, 0, n);
    step_chk("f3_39", 39, 0, 0, n);
    step_chk("f3_40", 40, 0, 0, n);
    chk("f3_p1_run", 32'(bus.pump1_run), 32'd1);

    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid", 32'({bus.water_lvl, bus.step, bus.pump1_run,
        bus.pump2_run, bus.both_on}), 32'd0);
    bus.pump1_ctrl = 1'b0;
    bus.pump2_ctrl = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
